// File: rtl/onehot_sequencer.sv
// Registered one-hot position sequencer with load, step and auto-walk.
// Commands arrive on a valid/ready port; all outputs come from flops.
module onehot_sequencer #(
  parameter int IDX_W = 3,
  parameter int DIV_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic                    cmd_dir,
  input  logic [IDX_W-1:0]        cmd_idx,
  input  logic [DIV_W-1:0]        cmd_div,
  output logic [(2**IDX_W)-1:0]   onehot,
  output logic [IDX_W-1:0]        idx,
  output logic                    running,
  output logic                    wrap
);

  localparam int OUT_W = 2**IDX_W;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_STOP = 2'b11;

  localparam logic [IDX_W-1:0] IDX_MAX = '1;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [0:0]       state;
  logic [0:0]       nstate;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] ncnt;
  logic [DIV_W-1:0] per;
  logic [DIV_W-1:0] nper;
  logic             dir_r;
  logic             ndir;
  logic [IDX_W-1:0] nidx;
  logic             nwrap;
  logic             accept;
  logic             tick;

  function automatic logic [IDX_W-1:0] step_idx(
    input logic [IDX_W-1:0] cur,
    input logic             dn
  );
    return dn ? cur - IDX_ONE : cur + IDX_ONE;
  endfunction

  function automatic logic wraps(
    input logic [IDX_W-1:0] cur,
    input logic             dn
  );
    return dn ? (cur == '0) : (cur == IDX_MAX);
  endfunction

  assign cmd_ready = ~rst;
  assign accept    = cmd_valid & cmd_ready;
  assign tick      = (state == S_RUN) && (cnt == '0);

  // An accepted command always overrides a coincident auto-step.
  always_comb begin
    nstate = state;
    nidx   = idx;
    nwrap  = 1'b0;
    nper   = per;
    ndir   = dir_r;
    ncnt   = cnt;
    if (state == S_RUN) begin
      ncnt = cnt - DIV_ONE;
    end
    if (accept) begin
      unique case (cmd_op)
        OP_LOAD: begin
          nidx   = cmd_idx;
          nstate = S_IDLE;
          ncnt   = '0;
        end
        OP_STEP: begin
          nidx  = step_idx(idx, cmd_dir);
          nwrap = wraps(idx, cmd_dir);
          if (state == S_RUN) begin
            ncnt = per;
          end
        end
        OP_RUN: begin
          nper   = cmd_div;
          ndir   = cmd_dir;
          ncnt   = cmd_div;
          nstate = S_RUN;
        end
        OP_STOP: begin
          nstate = S_IDLE;
          ncnt   = '0;
        end
        default: ;
      endcase
    end else if (tick) begin
      nidx  = step_idx(idx, dir_r);
      nwrap = wraps(idx, dir_r);
      ncnt  = per;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      onehot  <= OUT_W'(1);
      running <= 1'b0;
      wrap    <= 1'b0;
      cnt     <= '0;
      per     <= '0;
      dir_r   <= 1'b0;
    end else begin
      state   <= nstate;
      idx     <= nidx;
      onehot  <= OUT_W'(1) << nidx;
      running <= (nstate == S_RUN);
      wrap    <= nwrap;
      cnt     <= ncnt;
      per     <= nper;
      dir_r   <= ndir;
    end
  end

endmodule

// File: tb/tb_onehot_sequencer.sv
// Scoreboard bench for onehot_sequencer.
// Driver queues expected outputs; a negedge monitor pops and compares.
module tb_onehot_sequencer;

  localparam logic [1:0] LD = 2'b00;
  localparam logic [1:0] ST = 2'b01;
  localparam logic [1:0] RN = 2'b10;
  localparam logic [1:0] SP = 2'b11;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_dir;
  logic [2:0] cmd_idx;
  logic [7:0] cmd_div;
  logic [7:0] onehot;
  logic [2:0] idx;
  logic       running;
  logic       wrap;

  typedef struct packed {
    logic [2:0] idx;
    logic       run;
    logic       wrap;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_fail;

  onehot_sequencer #(.IDX_W(3), .DIV_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dir   (cmd_dir),
    .cmd_idx   (cmd_idx),
    .cmd_div   (cmd_div),
    .onehot    (onehot),
    .idx       (idx),
    .running   (running),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] eo;
    if (q.size() > 0) begin
      e  = q.pop_front();
      eo = 8'd1 << e.idx;
      chk("idx", 32'(idx), 32'(e.idx));
      chk("onehot", 32'(onehot), 32'(eo));
      chk("running", 32'(running), 32'(e.run));
      chk("wrap", 32'(wrap), 32'(e.wrap));
      chk("ready", 32'(cmd_ready), 32'(e.rdy));
    end
  end

  task automatic cyc(
    input logic       v,
    input logic [1:0] op,
    input logic       d,
    input logic [2:0] i,
    input logic [7:0] dv,
    input logic [2:0] ei,
    input logic       er,
    input logic       ew
  );
    exp_t e;
    cmd_valid = v;
    cmd_op    = op;
    cmd_dir   = d;
    cmd_idx   = i;
    cmd_div   = dv;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    e = '{idx: ei, run: er, wrap: ew, rdy: 1'b1};
    q.push_back(e);
  endtask

  task automatic cmd(
    input logic [1:0] op,
    input logic       d,
    input logic [2:0] i,
    input logic [7:0] dv,
    input logic [2:0] ei,
    input logic       er,
    input logic       ew
  );
    cyc(1'b1, op, d, i, dv, ei, er, ew);
  endtask

  task automatic nop(
    input logic [2:0] ei,
    input logic       er,
    input logic       ew
  );
    cyc(1'b0, LD, 1'b0, 3'd0, 8'd0, ei, er, ew);
  endtask

  task automatic chk_reset_now(input string tag);
    chk({tag, "_idx"}, 32'(idx), 32'd0);
    chk({tag, "_onehot"}, 32'(onehot), 32'h01);
    chk({tag, "_running"}, 32'(running), 32'd0);
    chk({tag, "_wrap"}, 32'(wrap), 32'd0);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd0);
  endtask

  initial begin
    logic [2:0] lv [6];
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = LD;
    cmd_dir   = 1'b0;
    cmd_idx   = 3'd0;
    cmd_div   = 8'd0;
    #2;
    chk_reset_now("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // LOAD sweep
    lv = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    for (int k = 0; k < 6; k++) begin
      cmd(LD, 1'b0, lv[k], 8'd0, lv[k], 1'b0, 1'b0);
    end

    // STEP wrap both ways
    cmd(LD, 1'b0, 3'd7, 8'd0, 3'd7, 1'b0, 1'b0);
    cmd(ST, 1'b0, 3'd0, 8'd0, 3'd0, 1'b0, 1'b1);
    nop(3'd0, 1'b0, 1'b0);
    cmd(ST, 1'b1, 3'd0, 8'd0, 3'd7, 1'b0, 1'b1);
    nop(3'd7, 1'b0, 1'b0);
    cmd(ST, 1'b1, 3'd0, 8'd0, 3'd6, 1'b0, 1'b0);

    // RUN up, div=2: one step every 3 cycles
    cmd(LD, 1'b0, 3'd0, 8'd0, 3'd0, 1'b0, 1'b0);
    cmd(RN, 1'b0, 3'd0, 8'd2, 3'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      nop(3'(k - 1), 1'b1, 1'b0);
      nop(3'(k - 1), 1'b1, 1'b0);
      nop(3'(k % 8), 1'b1, k == 8);
    end
    cmd(SP, 1'b0, 3'd0, 8'd0, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) nop(3'd0, 1'b0, 1'b0);

    // RUN down, div=0; STOP lands on an auto-step edge
    cmd(LD, 1'b0, 3'd1, 8'd0, 3'd1, 1'b0, 1'b0);
    cmd(RN, 1'b1, 3'd0, 8'd0, 3'd1, 1'b1, 1'b0);
    nop(3'd0, 1'b1, 1'b0);
    nop(3'd7, 1'b1, 1'b1);
    nop(3'd6, 1'b1, 1'b0);
    cmd(SP, 1'b0, 3'd0, 8'd0, 3'd6, 1'b0, 1'b0);
    nop(3'd6, 1'b0, 1'b0);

    // LOAD collides with auto-step
    cmd(LD, 1'b0, 3'd2, 8'd0, 3'd2, 1'b0, 1'b0);
    cmd(RN, 1'b0, 3'd0, 8'd3, 3'd2, 1'b1, 1'b0);
    nop(3'd2, 1'b1, 1'b0);
    nop(3'd2, 1'b1, 1'b0);
    nop(3'd2, 1'b1, 1'b0);
    cmd(LD, 1'b0, 3'd5, 8'd0, 3'd5, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) nop(3'd5, 1'b0, 1'b0);

    // STEP in RUN reloads the divider
    cmd(RN, 1'b0, 3'd0, 8'd3, 3'd5, 1'b1, 1'b0);
    nop(3'd5, 1'b1, 1'b0);
    nop(3'd5, 1'b1, 1'b0);
    cmd(ST, 1'b1, 3'd0, 8'd0, 3'd4, 1'b1, 1'b0);
    nop(3'd4, 1'b1, 1'b0);
    nop(3'd4, 1'b1, 1'b0);
    nop(3'd4, 1'b1, 1'b0);
    nop(3'd5, 1'b1, 1'b0);
    cmd(SP, 1'b0, 3'd0, 8'd0, 3'd5, 1'b0, 1'b0);

    // async reset while running at idx 6
    cmd(LD, 1'b0, 3'd4, 8'd0, 3'd4, 1'b0, 1'b0);
    cmd(RN, 1'b0, 3'd0, 8'd1, 3'd4, 1'b1, 1'b0);
    nop(3'd4, 1'b1, 1'b0);
    nop(3'd5, 1'b1, 1'b0);
    nop(3'd5, 1'b1, 1'b0);
    nop(3'd6, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_now("arst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) nop(3'd0, 1'b0, 1'b0);

    for (int k = 0; k < 50 && q.size() > 0; k++) @(negedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_sequencer.md
Name: onehot_sequencer

Overview:
- Parametrised, registered successor to the combinational index-to-one-hot decoder.
- Holds a one-hot position register that can be:
  - loaded from a binary index;
  - stepped up or down one position with wrap-around;
  - auto-walked at a programmable rate.
- Drives rotating channel selects, LED/scan chains and round-robin enables from a valid/ready command port.

Parameters:
- IDX_W, 3, width of the binary index; number of one-hot outputs is OUT_W = 2**IDX_W (local, derived).
- DIV_W, 8, width of the auto-walk rate divider.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command can be accepted.
- cmd_op  input  2  opcode: 00 LOAD, 01 STEP, 10 RUN, 11 STOP.
- cmd_dir  input  1  direction for STEP/RUN: 0 up (idx+1), 1 down (idx-1).
- cmd_idx  input  IDX_W  target index for LOAD.
- cmd_div  input  DIV_W  RUN period minus one.
- onehot  output  OUT_W  registered one-hot position; exactly one bit set at all times.
- idx  output  IDX_W  registered binary index of the set bit.
- running  output  1  high while in RUN state.
- wrap  output  1  one-cycle pulse on the cycle after the index wraps.

Behaviour:
- Reset (asynchronous, immediate on rst=1; also valid mid-operation):
  - idx=0, onehot=1, running=0, wrap=0;
  - divider counter=0, stored period=0, stored direction=0;
  - FSM goes to IDLE; cmd_ready=0 while rst is high.
- Handshake:
  - cmd_ready=1 whenever rst=0, in both states.
  - A command is accepted on a rising edge with cmd_valid & cmd_ready.
  - Commands take effect on that edge, so outputs show the result one cycle after acceptance.
- Invariant: onehot == (1 << idx) on every cycle; both come from the same registered state, never decoded from inputs.
- FSM states: IDLE, RUN.
- LOAD:
  - idx <= cmd_idx; next state IDLE.
  - Cancels RUN, clears the divider and running.
  - wrap stays 0.
- STEP:
  - idx <= idx±1 modulo OUT_W according to cmd_dir.
  - Allowed in IDLE or RUN. In RUN, the step is applied and the divider reloads from the stored period; state stays RUN.
- RUN:
  - Store cmd_div and cmd_dir, load counter=cmd_div, next state RUN.
  - idx is unchanged on the accept edge.
  - RUN while already running restarts with the new period and direction.
- STOP: next state IDLE, running=0, idx held. Legal (no-op) in IDLE.
- Auto-walk in RUN:
  - The counter decrements each cycle.
  - When counter==0, idx steps in the stored direction and the counter reloads with the stored period.
  - Period is (div+1) cycles; first auto-step occurs div+1 cycles after the accept edge.
  - div=0 steps every cycle.
- Wrap detection:
  - Up: idx goes OUT_W-1 -> 0. Down: idx goes 0 -> OUT_W-1.
  - Either raises wrap for exactly the cycle in which the new idx is visible, for both STEP and auto-walk.
- Simultaneous accepted command and auto-step on the same edge: the command wins, the auto-step is discarded, and any reload follows the command rules. Only a command-caused wrap can pulse.
- Arithmetic: index increment/decrement is IDX_W-bit modular; no out-of-range state exists.
- Reset asserted during RUN returns to IDLE, idx=0. There is no pending-state carry-over after release.

Test Plan:
- Reset then LOAD sweep: LOAD cmd_idx = 0,1,2,3,4,7 with IDX_W=3 -> onehot = 00000001, 00000010, 00000100, 00001000, 00010000, 10000000, each one cycle after acceptance; running=0, wrap=0 throughout.
- STEP wrap: LOAD 7, STEP up -> idx=0, onehot=00000001, wrap=1 for exactly one cycle. STEP down -> idx=7, onehot=10000000, wrap=1 for one cycle.
- RUN rate: LOAD 0, RUN up cmd_div=2 -> idx advances 1,2,3,... every 3 cycles, with the first advance 3 cycles after accept. After 8 steps idx=0 with a wrap pulse. STOP -> running=0, idx frozen for 20 cycles.
- RUN div=0 down from idx 1 -> idx 0, 7, 6 on consecutive cycles; wrap pulses with idx=7.
- Collision: RUN up div=3; issue LOAD 5 on the exact edge the counter hits 0 -> idx=5 (not previous+1), running=0, no wrap.
- Async reset mid-RUN: assert rst between clock edges while idx=6 -> outputs go immediately to idx=0, onehot=00000001, running=0, cmd_ready=0. After release, no auto-step occurs for 10 cycles.
